theta_plane_unit: RTL and testbench
===================================

# theta_plane_unit

Folded, parametrised successor to the combinational theta step. It processes one Keccak-f state as a stream of five y-planes: it accumulates column parities while buffering the planes, then emits the five theta-mixed planes. Lane width is parametrised to cover Keccak-f[25·w] for w ∈ {1,2,4,8,16,32,64}. A per-block bypass mode passes the state through unchanged. It sits in the permutation datapath between the state-load path and the rho/pi stage, using valid/ready handshakes on both sides.

## Interface
- LANE_SIZE, default 64, lane width w; legal values are 1, 2, 4, 8, 16, 32, 64.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  input plane valid.
- in_ready  out  1  unit can accept an input plane.
- in_plane  in  5·LANE_SIZE  lanes A[x][y] for the current y; lane x occupies bits [x·LANE_SIZE +: LANE_SIZE].
- in_bypass  in  1  bypass request; sampled only with plane y=0 and held for the whole block.
- out_valid  out  1  output plane valid.
- out_ready  in  1  downstream accepts the output plane.
- out_plane  out  5·LANE_SIZE  theta result A′[x][y], same packing as in_plane.
- out_y  out  3  y index of out_plane, 0..4.
- out_last  out  1  high when out_y == 4.

## Operation
- Two states: ACCUM and EMIT. A 3-bit plane counter `cnt` runs 0..4 in both states.
- ACCUM:
  - in_ready = 1, out_valid = 0.
  - On in_valid & in_ready: buf[cnt] ← in_plane.
  - Parity update: C ← (cnt==0 ? in_plane : C ^ in_plane), lane-wise.
  - If cnt==0, latch bypass ← in_bypass.
  - cnt increments. On the accept with cnt==4: cnt ← 0 and go to EMIT.
- EMIT:
  - in_ready = 0, out_valid = 1.
  - out_y = cnt.
  - D[x] = C[(x+4) mod 5] ^ rotl1(C[(x+1) mod 5]).
    - rotl1 is a left rotate by one bit within LANE_SIZE bits.
    - For LANE_SIZE=1, rotl1 is the identity.
  - out_plane lane x = buf[cnt][x] ^ D[x], or buf[cnt][x] if bypass.
  - On out_valid & out_ready: cnt increments. On the accept with cnt==4: cnt ← 0 and go to ACCUM.
- Input and output never handshake in the same cycle; the single buffer is not overlapped.
- in_plane is ignored when in_valid=0. Input data while in_ready=0 is don't-care.
- All arithmetic is bitwise XOR and rotation; there are no carries. Widths are exactly LANE_SIZE per lane.

## Timing
- Reset (rst=1 at an edge): state ← ACCUM, cnt ← 0, C ← 0, bypass ← 0, buf ← 0.
- Outputs while rst is high: in_ready = 0, out_valid = 0, out_y = 0, out_last = 0, out_plane = 0. Reset overrides any concurrent handshake.
- Reset mid-block, in either state, discards the partial block. The next accepted plane is y=0 of a new block.
- Throughput, no stalls: 5 input cycles plus 5 output cycles, i.e. 10 cycles per state.
- Latency: out_valid rises in the cycle after the 5th input accept. The first output plane is available 1 cycle after the last input plane.
- out_plane, out_y and out_last are driven combinationally from registers. They stay stable while out_valid=1 and out_ready=0.
- out_ready is ignored in ACCUM. in_valid is ignored in EMIT.
- After the last output accept, in_ready = 1 in the next cycle.

## Test plan
- All-zero state, LANE_SIZE=64, bypass=0, out_ready=1:
  - five zero planes in, then five zero planes out.
  - out_valid is high on cycles 6–10 after the first accept; out_last is high only on the 5th.
- Single bit A[0][0]=0x1, all else 0, LANE_SIZE=64:
  - every y has lane x=1 = 0x1 and lane x=4 = 0x2; lanes x=0,2,3 = 0 except y=0, x=0 = 0x1.
- LANE_SIZE=8, A[1][0]=0x80, all else 0:
  - every y has lane x=0 = 0x01 and lane x=2 = 0x80.
  - y=0 lane x=1 = 0x80; all other lanes are 0 (checks rotation wrap).
- Bypass: repeat the single-bit case with in_bypass=1 on plane 0.
  - Output equals input.
  - Toggling in_bypass on planes 1–4 has no effect.
- Backpressure: hold out_ready=0 for 3 cycles while out_y=2.
  - out_plane and out_y stay constant; in_ready stays 0.
  - On release, planes 2, 3, 4 complete in order.
- Reset mid-ACCUM: assert rst after 3 planes.
  - In the next cycle in_ready=1 and out_valid=0.
  - Feeding the single-bit state then gives exactly the single-bit result.
- LANE_SIZE=1 smoke test: A[0][0]=1 gives lanes x=1 and x=4 = 1 for all y.

Source files
------------

// File: rtl/theta_plane_unit.sv
// theta_plane_unit: folded Keccak theta step over a stream of five y-planes with per-block bypass
module theta_plane_unit #(
  parameter int LANE_SIZE = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [5*LANE_SIZE-1:0] in_plane,
  input  logic                   in_bypass,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [5*LANE_SIZE-1:0] out_plane,
  output logic [2:0]             out_y,
  output logic                   out_last
);
  localparam int L = LANE_SIZE;
  typedef enum logic {ACCUM, EMIT} state_t;
  state_t         state_q;
  logic [2:0]     cnt_q, cnt_d;
  logic [5*L-1:0] c_q, d;
  logic [5*L-1:0] buf_q [5];
  logic           byp_q, emit;
  for (genvar x = 0; x < 5; x++) begin : g_d
    logic [L-1:0] ca, cb;
    assign ca = c_q[((x+4)%5)*L +: L];
    assign cb = c_q[((x+1)%5)*L +: L];
    // the two shifts form a 1-bit rotate and collapse to identity when L == 1
    assign d[x*L +: L] = ca ^ (cb << 1) ^ (cb >> (L-1));
  end
  assign emit      = state_q == EMIT && !rst;
  assign cnt_d     = cnt_q == 3'd4 ? 3'd0 : cnt_q + 3'd1;
  assign in_ready  = state_q == ACCUM && !rst;
  assign out_valid = emit;
  assign out_y     = emit ? cnt_q : 3'd0;
  assign out_last  = out_y == 3'd4;
  assign out_plane = emit ? (byp_q ? buf_q[cnt_q] : buf_q[cnt_q] ^ d) : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      cnt_q   <= 3'd0;
      c_q     <= '0;
      byp_q   <= 1'b0;
      for (int i = 0; i < 5; i++) buf_q[i] <= '0;
    end else if (in_ready && in_valid) begin
      buf_q[cnt_q] <= in_plane;
      c_q          <= cnt_q == 3'd0 ? in_plane : c_q ^ in_plane;
      byp_q        <= cnt_q == 3'd0 ? in_bypass : byp_q;
      cnt_q        <= cnt_d;
      state_q      <= cnt_q == 3'd4 ? EMIT : ACCUM;
    end else if (emit && out_ready) begin
      cnt_q   <= cnt_d;
      state_q <= cnt_q == 3'd4 ? ACCUM : EMIT;
    end
  end
endmodule

// File: tb/tb_theta_plane_unit.sv
// tb_theta_plane_unit: lockstep check of 64-, 8- and 1-bit lane instances against a whole-state theta model
module tb_theta_plane_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, in_valid = 1'b0, in_bypass = 1'b0, out_ready = 1'b1;
  logic [319:0] i64 = '0, o64;
  logic [39:0]  i8 = '0, o8;
  logic [4:0]   i1 = '0, o1;
  logic r64, r8, r1, v64, v8, v1, l64, l8, l1;
  logic [2:0] y64, y8, y1;
  theta_plane_unit #(.LANE_SIZE(64)) u64 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r64),
    .in_plane(i64), .in_bypass(in_bypass), .out_valid(v64), .out_ready(out_ready), .out_plane(o64),
    .out_y(y64), .out_last(l64));
  theta_plane_unit #(.LANE_SIZE(8)) u8 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r8),
    .in_plane(i8), .in_bypass(in_bypass), .out_valid(v8), .out_ready(out_ready), .out_plane(o8),
    .out_y(y8), .out_last(l8));
  theta_plane_unit #(.LANE_SIZE(1)) u1 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r1),
    .in_plane(i1), .in_bypass(in_bypass), .out_valid(v1), .out_ready(out_ready), .out_plane(o1),
    .out_y(y1), .out_last(l1));
  int n_chk = 0, n_fail = 0;
  logic [63:0]  st [5][5];
  logic [319:0] g64 [5];
  logic [39:0]  g8 [5];
  logic [4:0]   g1 [5];
  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [319:0] model(input int lw, input int y, input bit th, input bit byp);
    logic [63:0] m, v, dd;
    logic [63:0] c [5];
    logic [319:0] r;
    r = '0;
    m = (lw == 64) ? '1 : (64'd1 << lw) - 64'd1;
    for (int x = 0; x < 5; x++) begin
      c[x] = '0;
      for (int yy = 0; yy < 5; yy++) c[x] ^= st[yy][x] & m;
    end
    for (int x = 0; x < 5; x++) begin
      v  = c[(x+1)%5];
      dd = c[(x+4)%5] ^ (((v << 1) | (v >> (lw-1))) & m);
      v  = st[y][x] & m;
      if (th && !byp) v ^= dd;
      for (int b = 0; b < lw; b++) r[x*lw+b] = v[b];
    end
    return r;
  endfunction
  task automatic fill(input int mode);
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++) st[y][x] = (mode == 3) ? {$urandom, $urandom} : 64'd0;
    if (mode == 1) st[0][0] = 64'h1;
    if (mode == 2) st[0][1] = 64'h80;
  endtask
  task automatic send(input bit byp, input bit tog, input int n);
    logic [319:0] p;
    for (int y = 0; y < n; y++) begin
      @(negedge clk);
      chk("in_ready_accum", {r64, r8, r1}, 3'b111);
      chk("out_valid_accum", {v64, v8, v1}, 3'b000);
      in_valid  = 1'b1;
      in_bypass = (y == 0 || !tog) ? byp : 1'($urandom);
      p = model(64, y, 0, 0); i64 = p;
      p = model(8, y, 0, 0);  i8 = p[39:0];
      p = model(1, y, 0, 0);  i1 = p[4:0];
    end
    @(negedge clk);
    in_valid  = 1'b0;
    in_bypass = 1'b0;
  endtask
  task automatic recv(input bit byp, input int stall);
    logic [319:0] p, q, s;
    logic [2:0] yv;
    for (int y = 0; y < 5; y++) begin
      if (y != 0) @(negedge clk);
      yv = y[2:0];
      chk("out_valid", {v64, v8, v1}, 3'b111);
      chk("in_ready_emit", {r64, r8, r1}, 3'b000);
      chk("out_y", {y64, y8, y1}, {yv, yv, yv});
      chk("out_last", {l64, l8, l1}, {3{y == 4}});
      p = model(64, y, 1, byp); chk("plane64", o64, p);
      q = model(8, y, 1, byp);  chk("plane8", o8, q);
      s = model(1, y, 1, byp);  chk("plane1", o1, s);
      g64[y] = o64; g8[y] = o8; g1[y] = o1;
      if (y == stall) begin
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("hold_plane64", o64, p);
          chk("hold_y", y64, yv);
          chk("hold_in_ready", r64, 1'b0);
          chk("hold_valid", v64, 1'b1);
        end
        out_ready = 1'b1;
      end
    end
    @(negedge clk);
    chk("in_ready_after", {r64, r8, r1}, 3'b111);
    chk("out_valid_after", {v64, v8, v1}, 3'b000);
  endtask
  task automatic chk_reset();
    chk("rst_in_ready", {r64, r8, r1}, 3'b000);
    chk("rst_out_valid", {v64, v8, v1}, 3'b000);
    chk("rst_out_y", {y64, y8, y1, l64, l8, l1}, '0);
    chk("rst_plane", {o64, o8, o1}, '0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk_reset();
    rst = 1'b0;
    #1 chk("post_rst_ready", {r64, r8, r1}, 3'b111);
    fill(0); send(0, 0, 5); recv(0, -1);
    fill(1); send(0, 0, 5); recv(0, -1);
    chk("single_bit_y0", g64[0], {64'h2, 64'h0, 64'h0, 64'h1, 64'h1});
    chk("single_bit_y3", g64[3], {64'h2, 64'h0, 64'h0, 64'h1, 64'h0});
    chk("lane1_y0", g1[0], 5'b10011);
    chk("lane1_y2", g1[2], 5'b10010);
    fill(2); send(0, 0, 5); recv(0, -1);
    chk("rot8_y0", g8[0], 40'h0000808001);
    chk("rot8_y1", g8[1], 40'h0000800001);
    fill(1); send(1, 1, 5); recv(1, -1);
    chk("bypass_y0", g64[0], 320'h1);
    chk("bypass_y4", g64[4], 320'h0);
    fill(3); send(0, 0, 5); recv(0, 2);
    fill(3); send(0, 0, 3);
    rst = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    chk_reset();
    rst = 1'b0; in_valid = 1'b0;
    #1 chk("mid_accum_rst_ready", {r64, v64}, 2'b10);
    fill(1); send(0, 0, 5); recv(0, -1);
    chk("after_rst_single_bit", g64[0], {64'h2, 64'h0, 64'h0, 64'h1, 64'h1});
    fill(3); send(1, 0, 5);
    chk("emit_entered", v64, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset();
    rst = 1'b0;
    #1 chk("mid_emit_rst_ready", {r64, v64}, 2'b10);
    for (int k = 0; k < 6; k++) begin
      bit b;
      int s;
      b = 1'($urandom);
      s = $urandom_range(0, 6);
      fill(3); send(b, 1, 5); recv(b, s);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
